// File: rtl/npu_pkg.sv
// Shared NPU definitions: score/index width defaults, argmax FSM encoding
// and the output-mux select codes that read back the argmax results.
package npu_pkg;
    localparam int NPU_DATA_W = 16;
    localparam int NPU_IDX_W  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] SEL_INDEX = 3'b010;
    localparam logic [2:0] SEL_MSB   = 3'b011;
    localparam logic [2:0] SEL_LSB   = 3'b100;
endpackage

// File: rtl/argmax_tracker.sv
// Tracks the largest signed score and its index over one NPU result scan and
// holds the published result for the output mux until the next publish.
module argmax_tracker
    import npu_pkg::*;
#(
    parameter int DATA_W = NPU_DATA_W,
    parameter int IDX_W  = NPU_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [IDX_W-1:0]  index_data,
    output logic [7:0]        msb_largest_data,
    output logic [7:0]        lsb_largest_data
);

    logic [1:0]               state_r;
    logic [1:0]               state_nxt_s;
    logic                     scan_r;
    logic                     done_r;
    logic                     overflow_r;
    logic [IDX_W:0]           cnt_r;
    logic                     max_vld_r;
    logic signed [DATA_W-1:0] max_r;
    logic [IDX_W-1:0]         max_idx_r;
    logic [DATA_W-1:0]        res_val_r;
    logic [IDX_W-1:0]         res_idx_r;

    logic                     accept_s;
    logic                     take_s;
    logic signed [DATA_W-1:0] new_max_s;
    logic [IDX_W-1:0]         new_idx_s;

    // Beat acceptance and running-max candidate; beats past the index range never compete.
    always_comb begin
        accept_s  = in_valid && scan_r && !start;
        take_s    = 1'b0;
        new_max_s = max_r;
        new_idx_s = max_idx_r;
        if (accept_s && !cnt_r[IDX_W] && (!max_vld_r || ($signed(in_data) > max_r))) begin
            take_s    = 1'b1;
            new_max_s = $signed(in_data);
            new_idx_s = cnt_r[IDX_W-1:0];
        end else begin
            take_s    = 1'b0;
        end
    end

    // Next-state logic; start overrides everything, including an in-flight scan.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_SCAN;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_SCAN: begin
                    if (accept_s && in_last) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_DONE: state_nxt_s = ST_DONE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register with status flags decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            scan_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            scan_r  <= (state_nxt_s == ST_SCAN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Running max, beat counter and published results; start leaves the published results untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            max_vld_r  <= 1'b0;
            max_r      <= '0;
            max_idx_r  <= '0;
            overflow_r <= 1'b0;
            res_val_r  <= '0;
            res_idx_r  <= '0;
        end else if (start) begin
            cnt_r      <= '0;
            max_vld_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            if (cnt_r[IDX_W]) begin
                overflow_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + {{IDX_W{1'b0}}, 1'b1};
            end
            if (take_s) begin
                max_r     <= new_max_s;
                max_idx_r <= new_idx_s;
                max_vld_r <= 1'b1;
            end
            if (in_last) begin
                res_val_r <= new_max_s;
                res_idx_r <= new_idx_s;
            end
        end
    end

    assign in_ready         = scan_r;
    assign busy             = scan_r;
    assign done             = done_r;
    assign overflow         = overflow_r;
    assign index_data       = res_idx_r;
    assign msb_largest_data = res_val_r[DATA_W-1:DATA_W-8];
    assign lsb_largest_data = res_val_r[7:0];

endmodule
